// File: rtl/masked_parallel_hpc1_driver_if.sv
// Handshake and share bus between the HPC1 driver and its environment.
// Carries the plaintext operand/result handshakes and the shared multiplier I/O.
interface masked_parallel_hpc1_driver_if #(
  parameter int NUM_SHARES = 2,
  parameter int BIT_WIDTH = 4
);
  logic in_valid;
  logic out_ready_in;
  logic [BIT_WIDTH-1:0] in_a;
  logic [BIT_WIDTH-1:0] in_b;
  logic [BIT_WIDTH-1:0] in_c;
  logic [3*(NUM_SHARES-1)-1:0][BIT_WIDTH-1:0] in_share_rand;
  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] out_a_t1;
  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] out_b_t0;
  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] out_c_t0;
  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] in_d;
  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] in_e;
  logic out_valid;
  logic in_ready;
  logic [BIT_WIDTH-1:0] out_d_plain;
  logic [BIT_WIDTH-1:0] out_e_plain;

  modport master (
    output in_valid, in_a, in_b, in_c, in_share_rand,
    output in_d, in_e, in_ready,
    input  out_ready_in, out_a_t1, out_b_t0, out_c_t0,
    input  out_valid, out_d_plain, out_e_plain
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, in_share_rand,
    input  in_d, in_e, in_ready,
    output out_ready_in, out_a_t1, out_b_t0, out_c_t0,
    output out_valid, out_d_plain, out_e_plain
  );
endinterface

// File: rtl/masked_parallel_hpc1_driver.sv
// Shares a/b/c for a parallel HPC1 multiplier pair and recombines d/e.
// b/c shares go out at t0, a shares at t1; results folded at a fixed latency.
module masked_parallel_hpc1_driver #(
  parameter int NUM_SHARES = 2,
  parameter int BIT_WIDTH = 4,
  parameter int MUL_LATENCY = 2
) (
  input logic in_clock,
  input logic in_reset,
  masked_parallel_hpc1_driver_if.slave bus
);
  localparam int N = NUM_SHARES;
  localparam int W = BIT_WIDTH;
  localparam int CW = $clog2(MUL_LATENCY + 1);

  typedef logic [N-1:0][W-1:0] sh_t;
  typedef enum logic [2:0] {IDLE, T0, T1, WAIT, DONE} state_t;

  state_t state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  sh_t a_new, b_new, c_new;
  sh_t a_hold, a_q, b_q, c_q;
  logic [W-1:0] d_fold, e_fold;
  logic [W-1:0] d_q, e_q;
  logic valid_q, ready_q;

  assign cnt_nxt = (cnt == CW'(MUL_LATENCY)) ? cnt : cnt + CW'(1);

  always_comb begin
    a_new = '0;
    b_new = '0;
    c_new = '0;
    a_new[N-1] = bus.in_a;
    b_new[N-1] = bus.in_b;
    c_new[N-1] = bus.in_c;
    for (int i = 0; i < N-1; i++) begin
      a_new[i] = bus.in_share_rand[i];
      b_new[i] = bus.in_share_rand[N-1+i];
      c_new[i] = bus.in_share_rand[2*N-2+i];
      a_new[N-1] ^= bus.in_share_rand[i];
      b_new[N-1] ^= bus.in_share_rand[N-1+i];
      c_new[N-1] ^= bus.in_share_rand[2*N-2+i];
    end
    d_fold = '0;
    e_fold = '0;
    for (int i = 0; i < N; i++) begin
      d_fold ^= bus.in_d[i];
      e_fold ^= bus.in_e[i];
    end
  end

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      state   <= IDLE;
      cnt     <= '0;
      a_hold  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      e_q     <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_hold  <= a_new;
            b_q     <= b_new;
            c_q     <= c_new;
            cnt     <= '0;
            ready_q <= 1'b0;
            state   <= T0;
          end
        end
        T0: begin
          a_q   <= a_hold;
          cnt   <= cnt_nxt;
          state <= T1;
        end
        T1: begin
          cnt   <= cnt_nxt;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt_nxt;
          // capture keys off the counter so any latency >= 2 works
          if (cnt == CW'(MUL_LATENCY)) begin
            d_q     <= d_fold;
            e_q     <= e_fold;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            valid_q <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (bus.in_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_ready_in = ready_q;
  assign bus.out_a_t1     = a_q;
  assign bus.out_b_t0     = b_q;
  assign bus.out_c_t0     = c_q;
  assign bus.out_valid    = valid_q;
  assign bus.out_d_plain  = d_q;
  assign bus.out_e_plain  = e_q;
endmodule
